ber_test_sequencer: RTL and testbench

- Run-control FSM for one BER measurement on the test controller datapath: the PRBS-7/PRBS-13 generator/checker plus its error and bit counters.
- Latches a test configuration on start, then holds channel reset, discards a settling window, and counts checked bits and bit errors up to a target length.
- Reports done with frozen results.
- Sits between the user control inputs and the data channel wrapper / test controller pair, replacing free-running counting with bounded, repeatable runs.

---
 rtl/ber_seq_pkg.sv | 19 +
 rtl/ber_test_sequencer_if.sv | 37 +++
 rtl/sat_counter.sv | 39 +++
 rtl/ber_test_sequencer.sv | 145 ++++++++++++++
 tb/tb_ber_test_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ber_seq_pkg.sv
// Shared types and defaults for the BER test sequencer.
// The state encoding is fixed at 3 bits with IDLE at zero, so a reset state register reads as idle.
package ber_seq_pkg;

    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned DEF_ERR_W    = 13;
    localparam int unsigned DEF_SETTLE_W = 8;

    localparam logic [DEF_ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StChReset = 3'd1,
        StSettle  = 3'd2,
        StMeasure = 3'd3,
        StDone    = 3'd4
    } state_e;

endpackage

// File: rtl/ber_test_sequencer_if.sv
// Control, checker-stream and result signals of one BER run.
// The master side is the user/checker; the slave side is the sequencer.
interface ber_test_sequencer_if
    import ber_seq_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned ERR_W    = DEF_ERR_W,
    parameter int unsigned SETTLE_W = DEF_SETTLE_W
) ();

    logic                start;
    logic                abort;
    logic                prbs_sel_in;
    logic [CNT_W-1:0]    target_bits;
    logic [SETTLE_W-1:0] settle_cycles;
    logic                bit_valid;
    logic                bit_error;

    logic                channel_reset;
    logic                prbs_sel;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    bit_count;
    logic [ERR_W-1:0]    err_count;
    logic                err_sat;

    modport master (
        output start, abort, prbs_sel_in, target_bits, settle_cycles, bit_valid, bit_error,
        input  channel_reset, prbs_sel, busy, done, bit_count, err_count, err_sat
    );

    modport slave (
        input  start, abort, prbs_sel_in, target_bits, settle_cycles, bit_valid, bit_error,
        output channel_reset, prbs_sel, busy, done, bit_count, err_count, err_sat
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
// The flag records any increment attempted while already at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 13
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count,
    output logic             o_sat
);

    logic [WIDTH-1:0] r_count;
    logic             r_sat;
    logic             w_at_max;

    assign w_at_max = (r_count == {WIDTH{1'b1}});

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (i_inc) begin
            if (w_at_max) begin
                r_sat <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;
    assign o_sat   = r_sat;

endmodule

// File: rtl/ber_test_sequencer.sv
// Run-control FSM for one bounded BER measurement: channel reset, settle window, counted window.
// Configuration is latched on start so the inputs may change freely during a run.
module ber_test_sequencer
    import ber_seq_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned ERR_W      = DEF_ERR_W,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned SETTLE_W   = DEF_SETTLE_W
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    ber_test_sequencer_if.slave ctrl
);

    localparam int unsigned RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e              r_state;
    state_e              w_state_next;

    logic                r_prbs_sel;
    logic [CNT_W-1:0]    r_target;
    logic [SETTLE_W-1:0] r_settle;
    logic [RST_W-1:0]    r_rst_cnt;
    logic [CNT_W-1:0]    r_bit_count;
    logic                r_done;

    logic                w_idle_like;
    logic                w_busy;
    logic                w_start_acc;
    logic                w_abort;
    logic                w_rst_last;
    logic                w_settle_bit;
    logic                w_settle_last;
    logic                w_meas_bit;
    logic                w_meas_last;
    logic [CNT_W-1:0]    w_bit_count_inc;
    logic [ERR_W-1:0]    w_err_count;
    logic                w_err_sat;

    assign w_idle_like     = (r_state == StIdle) || (r_state == StDone);
    assign w_busy          = (r_state == StChReset) || (r_state == StSettle) ||
                             (r_state == StMeasure);
    assign w_start_acc     = w_idle_like && ctrl.start;
    assign w_abort         = w_busy && ctrl.abort;
    assign w_rst_last      = (r_rst_cnt == '0);
    assign w_settle_bit    = (r_state == StSettle) && ctrl.bit_valid && !ctrl.abort;
    assign w_settle_last   = w_settle_bit && (r_settle == SETTLE_W'(1));
    // A bit arriving together with abort is dropped; abort wins over completion.
    assign w_meas_bit      = (r_state == StMeasure) && ctrl.bit_valid && !ctrl.abort;
    assign w_bit_count_inc = r_bit_count + 1'b1;
    assign w_meas_last     = w_meas_bit && (w_bit_count_inc == r_target);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (ctrl.start) w_state_next = StChReset;
                end
                StChReset: begin
                    if (w_rst_last) begin
                        if (r_target == '0) begin
                            w_state_next = StDone;
                        end else if (r_settle != '0) begin
                            w_state_next = StSettle;
                        end else begin
                            w_state_next = StMeasure;
                        end
                    end
                end
                StSettle: begin
                    if (w_settle_last) w_state_next = StMeasure;
                end
                StMeasure: begin
                    if (w_meas_last) w_state_next = StDone;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        ctrl.channel_reset = (r_state == StIdle) || (r_state == StChReset);
        ctrl.busy          = w_busy;
        ctrl.done          = r_done;
        ctrl.prbs_sel      = r_prbs_sel;
        ctrl.bit_count     = r_bit_count;
        ctrl.err_count     = w_err_count;
        ctrl.err_sat       = w_err_sat;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prbs_sel  <= 1'b0;
            r_target    <= '0;
            r_settle    <= '0;
            r_rst_cnt   <= '0;
            r_bit_count <= '0;
            r_done      <= 1'b0;
        end else begin
            // Pulse only on the entering edge so a held DONE does not repeat it.
            r_done <= (w_state_next == StDone) && (r_state != StDone);
            if (w_start_acc) begin
                r_prbs_sel  <= ctrl.prbs_sel_in;
                r_target    <= ctrl.target_bits;
                r_settle    <= ctrl.settle_cycles;
                r_rst_cnt   <= RST_W'(RST_CYCLES - 1);
                r_bit_count <= '0;
            end else begin
                if ((r_state == StChReset) && !w_rst_last) begin
                    r_rst_cnt <= r_rst_cnt - 1'b1;
                end
                if (w_settle_bit) begin
                    r_settle <= r_settle - 1'b1;
                end
                if (w_meas_bit) begin
                    r_bit_count <= w_bit_count_inc;
                end
            end
        end
    end

    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_clear   (w_start_acc),
        .i_inc     (w_meas_bit && ctrl.bit_error),
        .o_count   (w_err_count),
        .o_sat     (w_err_sat)
    );

endmodule

// File: tb/tb_ber_test_sequencer.sv
// Directed bench for ber_test_sequencer: one task per scenario, inline checks.
// A second instance with a 4-bit error counter exercises saturation.
module tb_ber_test_sequencer;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ber_test_sequencer_if #(.CNT_W(16), .ERR_W(13), .SETTLE_W(8)) bus ();
    ber_test_sequencer_if #(.CNT_W(16), .ERR_W(4),  .SETTLE_W(8)) bus2 ();

    ber_test_sequencer #(
        .CNT_W(16), .ERR_W(13), .RST_CYCLES(4), .SETTLE_W(8)
    ) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .ctrl      (bus.slave)
    );

    ber_test_sequencer #(
        .CNT_W(16), .ERR_W(4), .RST_CYCLES(4), .SETTLE_W(8)
    ) dut_sat (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .ctrl      (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.start = 0; bus.abort = 0; bus.prbs_sel_in = 0; bus.target_bits = 0;
        bus.settle_cycles = 0; bus.bit_valid = 0; bus.bit_error = 0;
        bus2.start = 0; bus2.abort = 0; bus2.prbs_sel_in = 0; bus2.target_bits = 0;
        bus2.settle_cycles = 0; bus2.bit_valid = 0; bus2.bit_error = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++; if (bus.channel_reset !== 1'b1) begin errors++;
            $display("FAIL reset_chrst got %b exp 1", bus.channel_reset); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++;
            $display("FAIL reset_busy_done got %b%b exp 00", bus.busy, bus.done); end
        checks++; if (bus.bit_count !== 16'd0 || bus.err_count !== 13'd0) begin errors++;
            $display("FAIL reset_counts got %0d/%0d exp 0/0", bus.bit_count, bus.err_count); end
        checks++; if (bus.err_sat !== 1'b0 || bus.prbs_sel !== 1'b0) begin errors++;
            $display("FAIL reset_sat_sel got %b%b exp 00", bus.err_sat, bus.prbs_sel); end
        checks++; if (bus2.channel_reset !== 1'b1) begin errors++;
            $display("FAIL reset_chrst2 got %b exp 1", bus2.channel_reset); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.channel_reset !== 1'b1 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL idle_after_reset got %b%b exp 10", bus.channel_reset, bus.busy); end
    endtask

    task automatic test_settle();
        int rst_hi = 0;
        int dones  = 0;
        bus.prbs_sel_in = 1; bus.target_bits = 10; bus.settle_cycles = 2; bus.start = 1;
        @(negedge clk);
        bus.start = 0; bus.prbs_sel_in = 0; bus.target_bits = 3; bus.settle_cycles = 0;
        checks++; if (bus.prbs_sel !== 1'b1 || bus.busy !== 1'b1) begin errors++;
            $display("FAIL settle_latch got sel=%b busy=%b exp 1/1", bus.prbs_sel, bus.busy); end
        for (int i = 0; i < 20 && bus.channel_reset; i++) begin
            rst_hi++;
            @(negedge clk);
        end
        checks++; if (rst_hi !== 4) begin errors++;
            $display("FAIL settle_rst_cycles got %0d exp 4", rst_hi); end
        for (int i = 0; i < 12; i++) begin
            bus.bit_valid = 1; bus.bit_error = (i < 2);
            @(negedge clk);
            if (bus.done) dones++;
            if (i == 1) begin
                checks++; if (bus.bit_count !== 16'd0) begin errors++;
                    $display("FAIL settle_discard got %0d exp 0", bus.bit_count); end
            end
            if (i == 11) begin
                checks++; if (bus.done !== 1'b1) begin errors++;
                    $display("FAIL settle_done_time got %b exp 1", bus.done); end
            end
        end
        // Keep bits flowing while DONE is held: results must stay frozen.
        for (int i = 0; i < 4; i++) begin
            bus.bit_valid = 1; bus.bit_error = 1;
            @(negedge clk);
            if (bus.done) dones++;
        end
        bus.bit_valid = 0; bus.bit_error = 0;
        checks++; if (dones !== 1) begin errors++;
            $display("FAIL settle_done_pulses got %0d exp 1", dones); end
        checks++; if (bus.bit_count !== 16'd10 || bus.err_count !== 13'd0) begin errors++;
            $display("FAIL settle_counts got %0d/%0d exp 10/0", bus.bit_count, bus.err_count); end
        checks++; if (bus.busy !== 1'b0 || bus.channel_reset !== 1'b0) begin errors++;
            $display("FAIL settle_done_state got busy=%b chrst=%b exp 0/0",
                     bus.busy, bus.channel_reset); end
    endtask

    task automatic test_errors();
        int n = 0;
        int dones = 0;
        int done_at = -1;
        int k;
        bus.target_bits = 8; bus.settle_cycles = 0; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        while (bus.channel_reset && n < 20) begin n++; @(negedge clk); end
        checks++; if (bus.channel_reset !== 1'b0 || bus.busy !== 1'b1) begin errors++;
            $display("FAIL errors_reach_measure got chrst=%b busy=%b exp 0/1",
                     bus.channel_reset, bus.busy); end
        for (int i = 0; i < 16; i++) begin
            k = i / 2 + 1;
            bus.bit_valid = (i % 2 == 0);
            bus.bit_error = (i % 2 == 0) && (k == 3 || k == 8);
            @(negedge clk);
            if (bus.done) begin dones++; done_at = i; end
        end
        bus.bit_valid = 0; bus.bit_error = 0;
        checks++; if (done_at !== 14 || dones !== 1) begin errors++;
            $display("FAIL errors_done got at=%0d n=%0d exp 14/1", done_at, dones); end
        checks++; if (bus.err_count !== 13'd2) begin errors++;
            $display("FAIL errors_err_count got %0d exp 2", bus.err_count); end
        checks++; if (bus.bit_count !== 16'd8) begin errors++;
            $display("FAIL errors_bit_count got %0d exp 8", bus.bit_count); end
    endtask

    task automatic test_abort();
        int n = 0;
        int dones = 0;
        int busy_seen = 0;
        bus.target_bits = 100; bus.settle_cycles = 0; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        while (bus.channel_reset && n < 20) begin n++; @(negedge clk); end
        for (int i = 0; i < 3; i++) begin
            bus.bit_valid = 1;
            if (i == 2) begin bus.start = 1; bus.target_bits = 5; end
            @(negedge clk);
            bus.start = 0;
        end
        bus.bit_valid = 0;
        checks++; if (bus.bit_count !== 16'd3 || bus.busy !== 1'b1) begin errors++;
            $display("FAIL abort_start_ignored got cnt=%0d busy=%b exp 3/1",
                     bus.bit_count, bus.busy); end
        bus.abort = 1; bus.start = 1;
        @(negedge clk);
        bus.abort = 0; bus.start = 0;
        checks++; if (bus.channel_reset !== 1'b1 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL abort_idle got chrst=%b busy=%b exp 1/0", bus.channel_reset, bus.busy); end
        checks++; if (bus.done !== 1'b0 || bus.bit_count !== 16'd3) begin errors++;
            $display("FAIL abort_partial got done=%b cnt=%0d exp 0/3", bus.done, bus.bit_count); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (bus.busy) busy_seen++;
        end
        checks++; if (dones !== 0 || busy_seen !== 0) begin errors++;
            $display("FAIL abort_quiet got done=%0d busy=%0d exp 0/0", dones, busy_seen); end
    endtask

    task automatic test_zero_target();
        int n = 0;
        bus.target_bits = 0; bus.settle_cycles = 5; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        while (bus.busy && n < 20) begin n++; @(negedge clk); end
        checks++; if (n !== 4) begin errors++;
            $display("FAIL zero_busy_cycles got %0d exp 4", n); end
        checks++; if (bus.done !== 1'b1 || bus.bit_count !== 16'd0) begin errors++;
            $display("FAIL zero_done got done=%b cnt=%0d exp 1/0", bus.done, bus.bit_count); end
        checks++; if (bus.channel_reset !== 1'b0) begin errors++;
            $display("FAIL zero_chrst got %b exp 0", bus.channel_reset); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++;
            $display("FAIL zero_done_once got %b exp 0", bus.done); end
    endtask

    task automatic test_saturate();
        int n = 0;
        int dones = 0;
        bus2.target_bits = 20; bus2.settle_cycles = 0; bus2.start = 1;
        @(negedge clk);
        bus2.start = 0;
        while (bus2.channel_reset && n < 20) begin n++; @(negedge clk); end
        for (int i = 0; i < 20; i++) begin
            bus2.bit_valid = 1; bus2.bit_error = 1;
            @(negedge clk);
            if (bus2.done) dones++;
            if (i == 14) begin
                checks++; if (bus2.err_count !== 4'd15 || bus2.err_sat !== 1'b0) begin errors++;
                    $display("FAIL sat_at_max got %0d/%b exp 15/0", bus2.err_count, bus2.err_sat);
                end
            end
        end
        bus2.bit_valid = 0; bus2.bit_error = 0;
        checks++; if (bus2.err_count !== 4'd15 || bus2.err_sat !== 1'b1) begin errors++;
            $display("FAIL sat_final got %0d/%b exp 15/1", bus2.err_count, bus2.err_sat); end
        checks++; if (bus2.bit_count !== 16'd20 || dones !== 1) begin errors++;
            $display("FAIL sat_bits got %0d/%0d exp 20/1", bus2.bit_count, dones); end
        bus2.target_bits = 0; bus2.start = 1;
        @(negedge clk);
        bus2.start = 0;
        checks++; if (bus2.err_count !== 4'd0 || bus2.err_sat !== 1'b0) begin errors++;
            $display("FAIL sat_cleared got %0d/%b exp 0/0", bus2.err_count, bus2.err_sat); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int n = 0;
        bus.prbs_sel_in = 1; bus.target_bits = 50; bus.settle_cycles = 1; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        while (bus.channel_reset && n < 20) begin n++; @(negedge clk); end
        for (int i = 0; i < 6; i++) begin
            bus.bit_valid = 1; bus.bit_error = 1;
            @(negedge clk);
        end
        checks++; if (bus.bit_count !== 16'd5 || bus.err_count !== 13'd5) begin errors++;
            $display("FAIL async_pre got %0d/%0d exp 5/5", bus.bit_count, bus.err_count); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.channel_reset !== 1'b1 || bus.busy !== 1'b0) begin errors++;
            $display("FAIL async_state got chrst=%b busy=%b exp 1/0", bus.channel_reset, bus.busy);
        end
        checks++; if (bus.bit_count !== 16'd0 || bus.err_count !== 13'd0 || bus.prbs_sel !== 1'b0)
        begin errors++;
            $display("FAIL async_outputs got %0d/%0d/%b exp 0/0/0",
                     bus.bit_count, bus.err_count, bus.prbs_sel); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.bit_valid = 0; bus.bit_error = 0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0 || bus.bit_count !== 16'd0) begin errors++;
            $display("FAIL async_after got busy=%b cnt=%0d exp 0/0", bus.busy, bus.bit_count); end
    endtask

    initial begin
        test_reset();
        test_settle();
        test_errors();
        test_abort();
        test_zero_target();
        test_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
